// File: rtl/sram_pkg.sv
// Shared SRAM arbiter types: default widths, FSM encoding, op codes and tie-break helper.
package sram_pkg;

   localparam int unsigned SRAM_AW = 16;
   localparam int unsigned SRAM_DW = 16;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ISSUE  = 2'd1,
      ST_SETTLE = 2'd2,
      ST_WAIT   = 2'd3
   } arb_state_e;

   typedef enum logic {
      OP_WR = 1'b0,
      OP_RD = 1'b1
   } sram_op_e;

   // Returns the port to grant; on a tie the port that won the previous tie loses.
   function automatic logic rr_pick(input logic req0, input logic req1, input logic tie_last);
      if (req0 && req1) begin
         return ~tie_last;
      end
      return req1;
   endfunction

endpackage

// File: rtl/sram_req_slot.sv
// One-deep pending request slot for a single arbiter port, plus that port's busy flag.
module sram_req_slot
   import sram_pkg::*;
#(
   parameter int unsigned AW = SRAM_AW,
   parameter int unsigned DW = SRAM_DW
) (
   input  logic          s_clk,
   input  logic          s_rst,
   input  logic          wr_req,
   input  logic          rd_req,
   input  logic [AW-1:0] req_addr,
   input  logic [DW-1:0] req_wdata,
   input  logic          active,
   input  logic          take,
   input  logic          done,
   output logic          pending,
   output sram_op_e      op,
   output logic [AW-1:0] addr,
   output logic [DW-1:0] wdata,
   output logic          busy
);

   logic accept_c;

   // Conflicting wr+rd pulses, a full slot or an in-flight op all drop the pulse silently.
   assign accept_c = (wr_req ^ rd_req) & ~pending & ~active;

   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         pending <= 1'b0;
         op      <= OP_WR;
         addr    <= '0;
         wdata   <= '0;
         busy    <= 1'b0;
      end else begin
         if (accept_c) begin
            pending <= 1'b1;
            op      <= rd_req ? OP_RD : OP_WR;
            addr    <= req_addr;
            wdata   <= req_wdata;
         end else if (take) begin
            pending <= 1'b0;
         end
         busy <= accept_c | (busy & ~done);
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Two-port arbiter in front of a single-command SRAM controller.
module sram_port_arbiter
   import sram_pkg::*;
#(
   parameter int unsigned AW = SRAM_AW,
   parameter int unsigned DW = SRAM_DW
) (
   input  logic          s_clk,
   input  logic          s_rst,
   input  logic          p0_wr_req,
   input  logic          p0_rd_req,
   input  logic [AW-1:0] p0_addr,
   input  logic [DW-1:0] p0_wdata,
   output logic [DW-1:0] p0_rdata,
   output logic          p0_done,
   output logic          p0_busy,
   input  logic          p1_wr_req,
   input  logic          p1_rd_req,
   input  logic [AW-1:0] p1_addr,
   input  logic [DW-1:0] p1_wdata,
   output logic [DW-1:0] p1_rdata,
   output logic          p1_done,
   output logic          p1_busy,
   output logic          s_wr_req,
   output logic          s_rd_req,
   output logic [AW-1:0] s_addr,
   output logic [DW-1:0] s_wdata,
   input  logic [DW-1:0] s_rdata,
   input  logic          s_valid,
   input  logic          s_busy
);

   arb_state_e    state_q, nxt_state;
   logic          gnt_q, nxt_gnt;
   sram_op_e      op_q, nxt_op;
   logic          tie_last_q, nxt_tie_last;
   logic          pick_c;

   logic          nxt_s_wr_req, nxt_s_rd_req;
   logic [AW-1:0] nxt_s_addr;
   logic [DW-1:0] nxt_s_wdata;
   logic          nxt_p0_done, nxt_p1_done;
   logic [DW-1:0] nxt_p0_rdata, nxt_p1_rdata;

   logic          slot0_pending, slot1_pending;
   sram_op_e      slot0_op, slot1_op;
   logic [AW-1:0] slot0_addr, slot1_addr;
   logic [DW-1:0] slot0_wdata, slot1_wdata;

   logic          active0_c, active1_c, take0_c, take1_c;

   assign active0_c = (state_q != ST_IDLE) && !gnt_q;
   assign active1_c = (state_q != ST_IDLE) &&  gnt_q;
   assign take0_c   = (state_q == ST_ISSUE) && !gnt_q;
   assign take1_c   = (state_q == ST_ISSUE) &&  gnt_q;

   sram_req_slot #(.AW(AW), .DW(DW)) u_slot0 (
      .s_clk     (s_clk),
      .s_rst     (s_rst),
      .wr_req    (p0_wr_req),
      .rd_req    (p0_rd_req),
      .req_addr  (p0_addr),
      .req_wdata (p0_wdata),
      .active    (active0_c),
      .take      (take0_c),
      .done      (p0_done),
      .pending   (slot0_pending),
      .op        (slot0_op),
      .addr      (slot0_addr),
      .wdata     (slot0_wdata),
      .busy      (p0_busy)
   );

   sram_req_slot #(.AW(AW), .DW(DW)) u_slot1 (
      .s_clk     (s_clk),
      .s_rst     (s_rst),
      .wr_req    (p1_wr_req),
      .rd_req    (p1_rd_req),
      .req_addr  (p1_addr),
      .req_wdata (p1_wdata),
      .active    (active1_c),
      .take      (take1_c),
      .done      (p1_done),
      .pending   (slot1_pending),
      .op        (slot1_op),
      .addr      (slot1_addr),
      .wdata     (slot1_wdata),
      .busy      (p1_busy)
   );

   // State and registered outputs; reset abandons any in-flight command without a done.
   always_ff @(posedge s_clk) begin
      if (s_rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= 1'b0;
         op_q       <= OP_WR;
         tie_last_q <= 1'b1;
         s_wr_req   <= 1'b0;
         s_rd_req   <= 1'b0;
         s_addr     <= '0;
         s_wdata    <= '0;
         p0_done    <= 1'b0;
         p1_done    <= 1'b0;
         p0_rdata   <= '0;
         p1_rdata   <= '0;
      end else begin
         state_q    <= nxt_state;
         gnt_q      <= nxt_gnt;
         op_q       <= nxt_op;
         tie_last_q <= nxt_tie_last;
         s_wr_req   <= nxt_s_wr_req;
         s_rd_req   <= nxt_s_rd_req;
         s_addr     <= nxt_s_addr;
         s_wdata    <= nxt_s_wdata;
         p0_done    <= nxt_p0_done;
         p1_done    <= nxt_p1_done;
         p0_rdata   <= nxt_p0_rdata;
         p1_rdata   <= nxt_p1_rdata;
      end
   end

   // Next-state and next-output logic; the command pulse is set up on the grant edge.
   always_comb begin
      nxt_state    = state_q;
      nxt_gnt      = gnt_q;
      nxt_op       = op_q;
      nxt_tie_last = tie_last_q;
      pick_c       = 1'b0;
      nxt_s_wr_req = 1'b0;
      nxt_s_rd_req = 1'b0;
      nxt_s_addr   = s_addr;
      nxt_s_wdata  = s_wdata;
      nxt_p0_done  = 1'b0;
      nxt_p1_done  = 1'b0;
      nxt_p0_rdata = p0_rdata;
      nxt_p1_rdata = p1_rdata;

      unique case (state_q)
         ST_IDLE: begin
            if (slot0_pending || slot1_pending) begin
               pick_c = rr_pick(slot0_pending, slot1_pending, tie_last_q);
               // Pointer only moves on contested grants.
               if (slot0_pending && slot1_pending) begin
                  nxt_tie_last = pick_c;
               end
               nxt_gnt      = pick_c;
               nxt_op       = pick_c ? slot1_op : slot0_op;
               nxt_s_wr_req = (nxt_op == OP_WR);
               nxt_s_rd_req = (nxt_op == OP_RD);
               nxt_s_addr   = pick_c ? slot1_addr : slot0_addr;
               nxt_s_wdata  = pick_c ? slot1_wdata : slot0_wdata;
               nxt_state    = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            nxt_state = ST_SETTLE;
         end
         ST_SETTLE: begin
            nxt_state = ST_WAIT;
         end
         ST_WAIT: begin
            if (op_q == OP_RD) begin
               if (s_valid) begin
                  if (gnt_q) begin
                     nxt_p1_rdata = s_rdata;
                     nxt_p1_done  = 1'b1;
                  end else begin
                     nxt_p0_rdata = s_rdata;
                     nxt_p0_done  = 1'b1;
                  end
                  nxt_state = ST_IDLE;
               end
            end else if (!s_busy) begin
               nxt_p0_done = !gnt_q;
               nxt_p1_done = gnt_q;
               nxt_state   = ST_IDLE;
            end
         end
         default: begin
            nxt_state = ST_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed self-checking bench for sram_port_arbiter: cycle table plus multi-cycle sequences.
module tb_sram_port_arbiter;

   logic        s_clk;
   logic        s_rst;
   logic        p0_wr_req, p0_rd_req, p1_wr_req, p1_rd_req;
   logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
   logic [15:0] p0_rdata, p1_rdata;
   logic        p0_done, p0_busy, p1_done, p1_busy;
   logic        s_wr_req, s_rd_req;
   logic [15:0] s_addr, s_wdata, s_rdata;
   logic        s_valid, s_busy;

   int n_checks;
   int n_fail;
   int n_req, n_done0, n_done1;

   sram_port_arbiter #(.AW(16), .DW(16)) dut (
      .s_clk     (s_clk),
      .s_rst     (s_rst),
      .p0_wr_req (p0_wr_req),
      .p0_rd_req (p0_rd_req),
      .p0_addr   (p0_addr),
      .p0_wdata  (p0_wdata),
      .p0_rdata  (p0_rdata),
      .p0_done   (p0_done),
      .p0_busy   (p0_busy),
      .p1_wr_req (p1_wr_req),
      .p1_rd_req (p1_rd_req),
      .p1_addr   (p1_addr),
      .p1_wdata  (p1_wdata),
      .p1_rdata  (p1_rdata),
      .p1_done   (p1_done),
      .p1_busy   (p1_busy),
      .s_wr_req  (s_wr_req),
      .s_rd_req  (s_rd_req),
      .s_addr    (s_addr),
      .s_wdata   (s_wdata),
      .s_rdata   (s_rdata),
      .s_valid   (s_valid),
      .s_busy    (s_busy)
   );

   initial s_clk = 1'b0;
   always #5 s_clk = ~s_clk;

   // Pulse monitor, sampled away from the active edge.
   initial begin
      n_req = 0; n_done0 = 0; n_done1 = 0;
   end
   always @(negedge s_clk) begin
      if (s_wr_req || s_rd_req) n_req = n_req + 1;
      if (p0_done) n_done0 = n_done0 + 1;
      if (p1_done) n_done1 = n_done1 + 1;
   end

   typedef struct {
      logic        wr0, rd0;
      logic [15:0] a0, d0;
      logic        wr1, rd1;
      logic [15:0] a1;
      logic        sb, sv;
      logic [15:0] sr;
      logic        e_wr, e_rd;
      logic [15:0] e_addr, e_wdata;
      logic        e_d0, e_b0, e_d1, e_b1;
      logic [15:0] e_r0, e_r1;
   } vec_t;

   vec_t vecs[13];

   task automatic step();
      @(posedge s_clk);
      #1;
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      n_checks = n_checks + 1;
      if (act != exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic clear_inputs();
      p0_wr_req = 1'b0; p0_rd_req = 1'b0; p0_addr = '0; p0_wdata = '0;
      p1_wr_req = 1'b0; p1_rd_req = 1'b0; p1_addr = '0; p1_wdata = '0;
   endtask

   task automatic check_all_zero(input string tag);
      chk1 ({tag, "_s_wr"},  s_wr_req, 1'b0);
      chk1 ({tag, "_s_rd"},  s_rd_req, 1'b0);
      chk16({tag, "_s_addr"}, s_addr, 16'h0);
      chk16({tag, "_s_wdata"}, s_wdata, 16'h0);
      chk1 ({tag, "_p0_done"}, p0_done, 1'b0);
      chk1 ({tag, "_p0_busy"}, p0_busy, 1'b0);
      chk1 ({tag, "_p1_done"}, p1_done, 1'b0);
      chk1 ({tag, "_p1_busy"}, p1_busy, 1'b0);
      chk16({tag, "_p0_rdata"}, p0_rdata, 16'h0);
      chk16({tag, "_p1_rdata"}, p1_rdata, 16'h0);
   endtask

   task automatic do_reset();
      s_rst = 1'b1;
      clear_inputs();
      s_valid = 1'b0; s_busy = 1'b0; s_rdata = '0;
      step(); step();
      s_rst = 1'b0;
   endtask

   // Wait for a read command, check its address, answer it and check the completion.
   task automatic serve_read(input int port, input logic [15:0] exp_addr, input logic [15:0] rd);
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         step();
         if (s_rd_req) seen = 1'b1;
      end
      chk1($sformatf("rd_issue_p%0d", port), seen, 1'b1);
      chk16($sformatf("rd_addr_p%0d", port), s_addr, exp_addr);
      step(); step();
      s_valid = 1'b1; s_rdata = rd;
      step();
      s_valid = 1'b0; s_rdata = '0;
      chk1($sformatf("rd_done_p%0d", port), port == 1 ? p1_done : p0_done, 1'b1);
      chk1($sformatf("rd_other_done_p%0d", port), port == 1 ? p0_done : p1_done, 1'b0);
      chk16($sformatf("rd_data_p%0d", port), port == 1 ? p1_rdata : p0_rdata, rd);
   endtask

   initial begin
      int   base_req, base_d0, base_d1;
      logic seen;
      n_checks = 0;
      n_fail   = 0;

      //          wr0 rd0 a0       d0       wr1 rd1 a1       sb  sv  sr       e_wr e_rd e_addr   e_wdata  d0 b0 d1 b1 e_r0   e_r1
      vecs[0]  = '{1, 0, 16'h0010, 16'hBEEF, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 1, 0, 0, 16'h0, 16'h0};
      vecs[1]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0010, 16'hBEEF, 0, 1, 0, 0, 16'h0, 16'h0};
      vecs[2]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0010, 16'hBEEF, 0, 1, 0, 0, 16'h0, 16'h0};
      vecs[3]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0010, 16'hBEEF, 0, 1, 0, 0, 16'h0, 16'h0};
      vecs[4]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h0010, 16'hBEEF, 0, 1, 0, 0, 16'h0, 16'h0};
      vecs[5]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0010, 16'hBEEF, 1, 1, 0, 0, 16'h0, 16'h0};
      vecs[6]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0010, 16'hBEEF, 0, 0, 0, 0, 16'h0, 16'h0};
      vecs[7]  = '{0, 0, 16'h0000, 16'h0000, 0, 1, 16'h1234, 0, 0, 16'h0000, 0, 0, 16'h0010, 16'hBEEF, 0, 0, 0, 1, 16'h0, 16'h0};
      vecs[8]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'h1234, 16'h0000, 0, 0, 0, 1, 16'h0, 16'h0};
      vecs[9]  = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 1, 16'h0, 16'h0};
      vecs[10] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 1, 0, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 1, 16'h0, 16'h0};
      vecs[11] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 1, 16'hA5A5, 0, 0, 16'h1234, 16'h0000, 0, 0, 1, 1, 16'h0, 16'hA5A5};
      vecs[12] = '{0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0, 0, 0, 0, 16'h0, 16'hA5A5};

      do_reset();
      check_all_zero("reset");

      // Port-0 write then port-1 read, cycle by cycle.
      for (int i = 0; i < 13; i++) begin
         p0_wr_req = vecs[i].wr0; p0_rd_req = vecs[i].rd0;
         p0_addr   = vecs[i].a0;  p0_wdata  = vecs[i].d0;
         p1_wr_req = vecs[i].wr1; p1_rd_req = vecs[i].rd1;
         p1_addr   = vecs[i].a1;  p1_wdata  = 16'h0;
         s_busy    = vecs[i].sb;  s_valid   = vecs[i].sv; s_rdata = vecs[i].sr;
         step();
         chk1 ($sformatf("v%0d_s_wr", i),     s_wr_req, vecs[i].e_wr);
         chk1 ($sformatf("v%0d_s_rd", i),     s_rd_req, vecs[i].e_rd);
         chk16($sformatf("v%0d_s_addr", i),   s_addr,   vecs[i].e_addr);
         chk16($sformatf("v%0d_s_wdata", i),  s_wdata,  vecs[i].e_wdata);
         chk1 ($sformatf("v%0d_p0_done", i),  p0_done,  vecs[i].e_d0);
         chk1 ($sformatf("v%0d_p0_busy", i),  p0_busy,  vecs[i].e_b0);
         chk1 ($sformatf("v%0d_p1_done", i),  p1_done,  vecs[i].e_d1);
         chk1 ($sformatf("v%0d_p1_busy", i),  p1_busy,  vecs[i].e_b1);
         chk16($sformatf("v%0d_p0_rdata", i), p0_rdata, vecs[i].e_r0);
         chk16($sformatf("v%0d_p1_rdata", i), p1_rdata, vecs[i].e_r1);
      end
      clear_inputs();
      s_busy = 1'b0; s_valid = 1'b0; s_rdata = '0;

      // Simultaneous reads: first tie after reset goes to p0, next tie to p1.
      do_reset();
      p0_rd_req = 1'b1; p0_addr = 16'h0001;
      p1_rd_req = 1'b1; p1_addr = 16'h0002;
      step();
      clear_inputs();
      serve_read(0, 16'h0001, 16'h1111);
      chk1("tie1_p1_still_busy", p1_busy, 1'b1);
      serve_read(1, 16'h0002, 16'h2222);
      step();
      p0_rd_req = 1'b1; p0_addr = 16'h0003;
      p1_rd_req = 1'b1; p1_addr = 16'h0004;
      step();
      clear_inputs();
      serve_read(1, 16'h0004, 16'h3333);
      serve_read(0, 16'h0003, 16'h4444);
      step();

      // Re-pulse on the active port is dropped in ISSUE, SETTLE and WAIT.
      do_reset();
      base_req = n_req; base_d0 = n_done0;
      p0_rd_req = 1'b1; p0_addr = 16'h0030;
      step();
      clear_inputs();
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (s_rd_req) seen = 1'b1;
      end
      chk1("drop_issue_seen", seen, 1'b1);
      for (int k = 0; k < 3; k++) begin
         p0_wr_req = 1'b1; p0_addr = 16'h0055; p0_wdata = 16'h1234;
         step();
      end
      clear_inputs();
      s_valid = 1'b1; s_rdata = 16'h0BAD;
      step();
      s_valid = 1'b0; s_rdata = '0;
      chk1 ("drop_done", p0_done, 1'b1);
      chk16("drop_rdata", p0_rdata, 16'h0BAD);
      for (int k = 0; k < 8; k++) step();
      chk_int("drop_req_count", n_req - base_req, 1);
      chk_int("drop_done_count", n_done0 - base_d0, 1);
      chk1 ("drop_busy_clear", p0_busy, 1'b0);
      chk16("drop_addr_kept", s_addr, 16'h0030);

      // Reset in WAIT of a p1 read, then a stray s_valid.
      base_d0 = n_done0; base_d1 = n_done1;
      p1_rd_req = 1'b1; p1_addr = 16'h0077;
      step();
      clear_inputs();
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step();
         if (s_rd_req) seen = 1'b1;
      end
      chk1("rst_issue_seen", seen, 1'b1);
      step(); step();
      s_rst = 1'b1;
      step();
      check_all_zero("rst_wait");
      s_rst = 1'b0;
      s_valid = 1'b1; s_rdata = 16'hFFFF;
      step(); step();
      s_valid = 1'b0; s_rdata = '0;
      step();
      check_all_zero("rst_stray");
      chk_int("rst_no_done", (n_done0 - base_d0) + (n_done1 - base_d1), 0);
      p0_wr_req = 1'b1; p0_addr = 16'h0099; p0_wdata = 16'h5A5A;
      step();
      clear_inputs();
      step();
      chk1 ("rst_idle_wr", s_wr_req, 1'b1);
      chk16("rst_idle_addr", s_addr, 16'h0099);
      step(); step(); step();
      chk1 ("rst_idle_done", p0_done, 1'b1);
      step();

      // Conflicting wr+rd on one port is not captured.
      base_req = n_req;
      p0_wr_req = 1'b1; p0_rd_req = 1'b1; p0_addr = 16'h00AA; p0_wdata = 16'h1111;
      step();
      clear_inputs();
      chk1("both_busy_now", p0_busy, 1'b0);
      for (int k = 0; k < 5; k++) step();
      chk1("both_busy_later", p0_busy, 1'b0);
      chk_int("both_no_req", n_req - base_req, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
